// File: rtl/pattern_detector_pkg.sv
// pattern_detector_pkg
//   Shared types and constants for the serial pattern detector.
//   - state_t   : detector FSM state (IDLE, FILL, ARMED)
//   - DEF_CNT_W : default width of the match counter
package pattern_detector_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } state_t;

    localparam int unsigned DEF_CNT_W = 16;

endpackage

// File: rtl/pattern_detector_sat_counter.sv
// sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clk   - clock, rising edge
//     rstn  - asynchronous active-low reset, clears count
//     clr   - synchronous clear (wins over inc)
//     inc   - increment request
//     count - current count value
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pattern_detector.sv
// pattern_detector
//   Serial bit-pattern detector with configurable pattern, overlap mode
//   and a saturating match counter.
//   Ports:
//     clk          - clock, rising edge
//     rstn         - asynchronous active-low reset
//     din          - serial data bit
//     din_valid    - qualifies din
//     enable       - detection enable; low freezes history/fill/count
//     cfg_load     - strobe: latch cfg_pattern/cfg_overlap, clear state
//     cfg_pattern  - pattern to detect, MSB is the first-received bit
//     cfg_overlap  - 1 = overlapping matches, 0 = restart after a match
//     dout_mealy   - combinational match pulse on the last pattern bit
//     dout_moore   - dout_mealy delayed by one cycle
//     match_count  - saturating number of matches since reset/cfg_load
//     armed        - FSM is in ARMED
module pattern_detector
    import pattern_detector_pkg::*;
#(
    parameter int unsigned PAT_LEN = 4,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               din,
    input  logic               din_valid,
    input  logic               enable,
    input  logic               cfg_load,
    input  logic [PAT_LEN-1:0] cfg_pattern,
    input  logic               cfg_overlap,
    output logic               dout_mealy,
    output logic               dout_moore,
    output logic [CNT_W-1:0]   match_count,
    output logic               armed
);

    localparam int unsigned       FILL_W   = $clog2(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

    state_t             state, state_nxt;
    logic [PAT_LEN-1:0] history, history_nxt;
    logic [FILL_W-1:0]  fill, fill_nxt, fill_inc;
    logic [PAT_LEN-1:0] pattern;
    logic               overlap;
    logic               accept;
    logic [PAT_LEN-1:0] window;

    always_comb begin
        accept     = din_valid && enable && !cfg_load;
        window     = {history[PAT_LEN-2:0], din};
        dout_mealy = (state == ARMED) && accept && (window == pattern);
        fill_inc   = (fill == FILL_MAX) ? fill : fill + FILL_W'(1);

        state_nxt   = state;
        history_nxt = history;
        fill_nxt    = fill;

        if (cfg_load) begin
            history_nxt = '0;
            fill_nxt    = '0;
            state_nxt   = enable ? FILL : IDLE;
        end else if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                // History and fill stay frozen for the wake-up cycle.
                IDLE: state_nxt = FILL;
                FILL: begin
                    if (accept) begin
                        history_nxt = window;
                        fill_nxt    = fill_inc;
                        if (fill_inc == FILL_MAX) begin
                            state_nxt = ARMED;
                        end
                    end
                end
                ARMED: begin
                    if (accept) begin
                        if (dout_mealy && !overlap) begin
                            history_nxt = '0;
                            fill_nxt    = '0;
                            state_nxt   = FILL;
                        end else begin
                            history_nxt = window;
                            fill_nxt    = fill_inc;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            history    <= '0;
            fill       <= '0;
            pattern    <= '1;
            overlap    <= 1'b1;
            dout_moore <= 1'b0;
        end else begin
            state      <= state_nxt;
            history    <= history_nxt;
            fill       <= fill_nxt;
            dout_moore <= dout_mealy;
            if (cfg_load) begin
                pattern <= cfg_pattern;
                overlap <= cfg_overlap;
            end
        end
    end

    assign armed = (state == ARMED);

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_count (
        .clk  (clk),
        .rstn (rstn),
        .clr  (cfg_load),
        .inc  (dout_mealy),
        .count(match_count)
    );

endmodule

// File: tb/tb_pattern_detector.sv
module tb_pattern_detector;

    logic        clk;
    logic        rstn;

    logic        din, din_valid, enable, cfg_load, cfg_overlap;
    logic [3:0]  cfg_pattern;
    logic        dout_mealy, dout_moore, armed;
    logic [15:0] match_count;

    logic        s_din, s_valid, s_enable, s_load, s_overlap;
    logic [1:0]  s_pattern;
    logic        s_mealy, s_moore, s_armed;
    logic [1:0]  s_count;

    int total;
    int bad;

    pattern_detector #(.PAT_LEN(4), .CNT_W(16)) u_dut (
        .clk(clk), .rstn(rstn), .din(din), .din_valid(din_valid),
        .enable(enable), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_overlap(cfg_overlap), .dout_mealy(dout_mealy),
        .dout_moore(dout_moore), .match_count(match_count), .armed(armed)
    );

    pattern_detector #(.PAT_LEN(2), .CNT_W(2)) u_sat (
        .clk(clk), .rstn(rstn), .din(s_din), .din_valid(s_valid),
        .enable(s_enable), .cfg_load(s_load), .cfg_pattern(s_pattern),
        .cfg_overlap(s_overlap), .dout_mealy(s_mealy),
        .dout_moore(s_moore), .match_count(s_count), .armed(s_armed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle on the main DUT at the falling edge, then sample.
    task automatic drive(input logic b, input logic v, output logic m, output logic mo);
        @(negedge clk);
        din       = b;
        din_valid = v;
        cfg_load  = 1'b0;
        #1;
        m  = dout_mealy;
        mo = dout_moore;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn      = 1'b0;
        enable    = 1'b0;
        din_valid = 1'b0;
        cfg_load  = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic load(input logic [3:0] p, input logic o);
        @(negedge clk);
        enable      = 1'b1;
        cfg_load    = 1'b1;
        cfg_pattern = p;
        cfg_overlap = o;
        din_valid   = 1'b0;
        @(negedge clk);
        cfg_load = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rstn = 1'b0; enable = 1'b1; din = 1'b1; din_valid = 1'b1;
        s_enable = 1'b1; s_din = 1'b1; s_valid = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        total += 5;
        if (dout_mealy !== 1'b0) begin bad++; $display("FAIL reset_mealy got=%b want=0", dout_mealy); end
        if (dout_moore !== 1'b0) begin bad++; $display("FAIL reset_moore got=%b want=0", dout_moore); end
        if (match_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", match_count); end
        if (armed !== 1'b0) begin bad++; $display("FAIL reset_armed got=%b want=0", armed); end
        if (s_count !== 2'd0) begin bad++; $display("FAIL reset_sat_count got=%0d want=0", s_count); end
        s_enable = 1'b0; s_valid = 1'b0; din_valid = 1'b0; enable = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_overlap();
        logic [6:0] bits = 7'b1011011;
        logic [6:0] exp  = 7'b0001001;
        logic m, mo, prev;
        do_reset();
        load(4'b1011, 1'b1);
        prev = 1'b0;
        for (int i = 6; i >= 0; i--) begin
            drive(bits[i], 1'b1, m, mo);
            total += 2;
            if (m !== exp[i]) begin bad++; $display("FAIL overlap_mealy bit%0d got=%b want=%b", 7 - i, m, exp[i]); end
            if (mo !== prev) begin bad++; $display("FAIL overlap_moore bit%0d got=%b want=%b", 7 - i, mo, prev); end
            prev = exp[i];
        end
        drive(1'b0, 1'b0, m, mo);
        total += 2;
        if (mo !== prev) begin bad++; $display("FAIL overlap_moore_last got=%b want=%b", mo, prev); end
        if (match_count !== 16'd2) begin bad++; $display("FAIL overlap_count got=%0d want=2", match_count); end
    endtask

    task automatic test_non_overlap();
        logic [6:0] bits = 7'b1011011;
        logic [6:0] exp  = 7'b0001000;
        logic m, mo, prev;
        do_reset();
        load(4'b1011, 1'b0);
        prev = 1'b0;
        for (int i = 6; i >= 0; i--) begin
            drive(bits[i], 1'b1, m, mo);
            total += 2;
            if (m !== exp[i]) begin bad++; $display("FAIL nonov_mealy bit%0d got=%b want=%b", 7 - i, m, exp[i]); end
            if (mo !== prev) begin bad++; $display("FAIL nonov_moore bit%0d got=%b want=%b", 7 - i, mo, prev); end
            prev = exp[i];
        end
        drive(1'b0, 1'b0, m, mo);
        total += 2;
        if (match_count !== 16'd1) begin bad++; $display("FAIL nonov_count got=%0d want=1", match_count); end
        // bits 5..7 refill three positions after the restart
        if (armed !== 1'b1) begin bad++; $display("FAIL nonov_armed got=%b want=1", armed); end
    endtask

    task automatic test_gaps();
        logic [6:0] bits = 7'b1011011;
        logic [6:0] exp  = 7'b0001001;
        logic m, mo, prev;
        do_reset();
        load(4'b1011, 1'b1);
        prev = 1'b0;
        for (int i = 6; i >= 0; i--) begin
            drive(bits[i], 1'b1, m, mo);
            total += 2;
            if (m !== exp[i]) begin bad++; $display("FAIL gaps_mealy bit%0d got=%b want=%b", 7 - i, m, exp[i]); end
            if (mo !== prev) begin bad++; $display("FAIL gaps_moore bit%0d got=%b want=%b", 7 - i, mo, prev); end
            prev = exp[i];
            drive(~bits[i], 1'b0, m, mo);
            total += 2;
            if (m !== 1'b0) begin bad++; $display("FAIL gaps_idle_mealy after bit%0d got=%b want=0", 7 - i, m); end
            if (mo !== prev) begin bad++; $display("FAIL gaps_idle_moore after bit%0d got=%b want=%b", 7 - i, mo, prev); end
            prev = 1'b0;
        end
        total += 1;
        if (match_count !== 16'd2) begin bad++; $display("FAIL gaps_count got=%0d want=2", match_count); end
    endtask

    task automatic test_cfg_collision();
        logic [3:0] bits = 4'b0110;
        logic [3:0] exp  = 4'b0001;
        logic m, mo;
        do_reset();
        load(4'b1011, 1'b1);
        drive(1'b1, 1'b1, m, mo);
        drive(1'b0, 1'b1, m, mo);
        drive(1'b1, 1'b1, m, mo);
        @(negedge clk);
        din = 1'b1; din_valid = 1'b1;
        cfg_load = 1'b1; cfg_pattern = 4'b0110; cfg_overlap = 1'b1;
        #1;
        total += 1;
        if (dout_mealy !== 1'b0) begin bad++; $display("FAIL coll_mealy got=%b want=0", dout_mealy); end
        @(posedge clk); #1;
        total += 2;
        if (match_count !== 16'd0) begin bad++; $display("FAIL coll_count got=%0d want=0", match_count); end
        if (armed !== 1'b0) begin bad++; $display("FAIL coll_armed got=%b want=0", armed); end
        for (int i = 3; i >= 0; i--) begin
            drive(bits[i], 1'b1, m, mo);
            total += 1;
            if (m !== exp[i]) begin bad++; $display("FAIL coll_new_mealy bit%0d got=%b want=%b", 4 - i, m, exp[i]); end
        end
        drive(1'b0, 1'b0, m, mo);
        total += 1;
        if (match_count !== 16'd1) begin bad++; $display("FAIL coll_new_count got=%0d want=1", match_count); end
    endtask

    task automatic test_enable_freeze();
        logic m, mo;
        do_reset();
        load(4'b1011, 1'b1);
        drive(1'b1, 1'b1, m, mo);
        drive(1'b0, 1'b1, m, mo);
        drive(1'b1, 1'b1, m, mo);
        @(negedge clk);
        enable = 1'b0; din = 1'b1; din_valid = 1'b1;
        #1;
        total += 1;
        if (dout_mealy !== 1'b0) begin bad++; $display("FAIL freeze_mealy got=%b want=0", dout_mealy); end
        @(posedge clk); #1;
        total += 2;
        if (armed !== 1'b0) begin bad++; $display("FAIL freeze_armed got=%b want=0", armed); end
        if (match_count !== 16'd0) begin bad++; $display("FAIL freeze_count got=%0d want=0", match_count); end
        din_valid = 1'b0;
    endtask

    task automatic test_saturate();
        logic [1:0] exp [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
        do_reset();
        @(negedge clk);
        s_enable = 1'b1; s_load = 1'b1; s_pattern = 2'b11; s_overlap = 1'b1; s_valid = 1'b0;
        @(negedge clk);
        s_load = 1'b0; s_din = 1'b1; s_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            total += 1;
            if (s_count !== exp[i]) begin bad++; $display("FAIL sat_count bit%0d got=%0d want=%0d", i + 1, s_count, exp[i]); end
        end
        @(negedge clk);
        s_valid = 1'b0; s_enable = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [5:0] bits = 6'b101101;
        logic m, mo;
        do_reset();
        load(4'b1011, 1'b1);
        for (int i = 5; i >= 0; i--) begin
            drive(bits[i], 1'b1, m, mo);
        end
        @(posedge clk); #1;
        total += 2;
        if (armed !== 1'b1) begin bad++; $display("FAIL areset_pre_armed got=%b want=1", armed); end
        if (match_count !== 16'd1) begin bad++; $display("FAIL areset_pre_count got=%0d want=1", match_count); end
        #1;
        rstn = 1'b0; din = 1'b1; din_valid = 1'b1;
        #1;
        total += 4;
        if (dout_mealy !== 1'b0) begin bad++; $display("FAIL areset_mealy got=%b want=0", dout_mealy); end
        if (dout_moore !== 1'b0) begin bad++; $display("FAIL areset_moore got=%b want=0", dout_moore); end
        if (match_count !== 16'd0) begin bad++; $display("FAIL areset_count got=%0d want=0", match_count); end
        if (armed !== 1'b0) begin bad++; $display("FAIL areset_armed got=%b want=0", armed); end
        #1;
        rstn = 1'b1;
        load(4'b1011, 1'b1);
        drive(1'b1, 1'b1, m, mo);
        total += 1;
        if (m !== 1'b0) begin bad++; $display("FAIL areset_after_mealy got=%b want=0", m); end
        drive(1'b0, 1'b0, m, mo);
        total += 1;
        if (match_count !== 16'd0) begin bad++; $display("FAIL areset_after_count got=%0d want=0", match_count); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rstn = 1'b0;
        din = 1'b0; din_valid = 1'b0; enable = 1'b0; cfg_load = 1'b0;
        cfg_pattern = 4'b0000; cfg_overlap = 1'b1;
        s_din = 1'b0; s_valid = 1'b0; s_enable = 1'b0; s_load = 1'b0;
        s_pattern = 2'b00; s_overlap = 1'b1;

        test_reset();
        test_overlap();
        test_non_overlap();
        test_gaps();
        test_cfg_collision();
        test_enable_freeze();
        test_saturate();
        test_async_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
